// File: rtl/timer_4bit_sched.sv
// Round-robin scheduler sharing one timer_4bit among N_REQ requesters (countdown mode).
// Optional RUN watchdog enabled by defining TIMER_4BIT_SCHED_WDOG_EN.
module timer_4bit_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned WDOG_LIMIT = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_delay,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 tmr_enable,
  output logic                 tmr_load,
  output logic                 tmr_mode,
  output logic [3:0]           tmr_preset,
  input  logic                 tmr_done,
  output logic                 err
);

  localparam int unsigned SUM_W  = ID_W + 1;
  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [ID_W-1:0]  r_rr_ptr, w_nxt_rr_ptr;
  logic [ID_W-1:0]  r_grant_id, w_nxt_grant_id;
  logic [N_REQ-1:0] r_ack, w_nxt_ack;
  logic             r_busy, w_nxt_busy;
  logic             r_tmr_enable, w_nxt_tmr_enable;
  logic             r_tmr_load, w_nxt_tmr_load;
  logic             r_tmr_mode, w_nxt_tmr_mode;
  logic [3:0]       r_tmr_preset, w_nxt_tmr_preset;
  logic             r_err, w_nxt_err;

  logic [N_REQ-1:0] w_rot;
  logic [ID_W-1:0]  w_off;
  logic             w_found;
  logic [SUM_W-1:0] w_sum;
  logic [ID_W-1:0]  w_pick;
  logic [ID_W-1:0]  w_rr_inc;
  logic [N_REQ-1:0] w_ack_vec;

`ifdef TIMER_4BIT_SCHED_WDOG_EN
  logic [WDOG_W-1:0] r_wdog, w_nxt_wdog;
`endif

  // Rotate requests so bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    w_rot   = N_REQ'({req, req} >> r_rr_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = ID_W'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= SUM_W'(N_REQ)) begin
      w_pick = ID_W'(w_sum - SUM_W'(N_REQ));
    end else begin
      w_pick = w_sum[ID_W-1:0];
    end
  end

  always_comb begin
    if (r_grant_id == ID_W'(N_REQ - 1)) begin
      w_rr_inc = '0;
    end else begin
      w_rr_inc = r_grant_id + ID_W'(1);
    end
    w_ack_vec = N_REQ'(1) << r_grant_id;
  end

  // Next state and next registered outputs.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_rr_ptr     = r_rr_ptr;
    w_nxt_grant_id   = r_grant_id;
    w_nxt_tmr_preset = r_tmr_preset;
    w_nxt_ack        = '0;
    w_nxt_busy       = 1'b0;
    w_nxt_tmr_enable = 1'b0;
    w_nxt_tmr_load   = 1'b0;
    w_nxt_tmr_mode   = 1'b0;
    w_nxt_err        = 1'b0;
`ifdef TIMER_4BIT_SCHED_WDOG_EN
    w_nxt_wdog       = r_wdog;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_state      = S_LOAD;
          w_nxt_grant_id   = w_pick;
          w_nxt_tmr_preset = req_delay[32'(w_pick) * 4 +: 4];
          w_nxt_busy       = 1'b1;
          w_nxt_tmr_load   = 1'b1;
          w_nxt_tmr_mode   = 1'b1;
`ifdef TIMER_4BIT_SCHED_WDOG_EN
          w_nxt_wdog       = '0;
`endif
        end
      end
      S_LOAD: begin
        w_nxt_state      = S_RUN;
        w_nxt_busy       = 1'b1;
        w_nxt_tmr_enable = 1'b1;
        w_nxt_tmr_mode   = 1'b1;
      end
      S_RUN: begin
        w_nxt_busy = 1'b1;
        if (tmr_done) begin
          w_nxt_state = S_DONE;
          w_nxt_ack   = w_ack_vec;
        end
`ifdef TIMER_4BIT_SCHED_WDOG_EN
        else if (r_wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
          w_nxt_state = S_DONE;
          w_nxt_ack   = w_ack_vec;
          w_nxt_err   = 1'b1;
        end
`endif
        else begin
          w_nxt_tmr_enable = 1'b1;
          w_nxt_tmr_mode   = 1'b1;
`ifdef TIMER_4BIT_SCHED_WDOG_EN
          w_nxt_wdog       = r_wdog + WDOG_W'(1);
`endif
        end
      end
      S_DONE: begin
        w_nxt_state  = S_IDLE;
        w_nxt_rr_ptr = w_rr_inc;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_tmr_enable <= 1'b0;
      r_tmr_load   <= 1'b0;
      r_tmr_mode   <= 1'b0;
      r_tmr_preset <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_rr_ptr     <= w_nxt_rr_ptr;
      r_grant_id   <= w_nxt_grant_id;
      r_ack        <= w_nxt_ack;
      r_busy       <= w_nxt_busy;
      r_tmr_enable <= w_nxt_tmr_enable;
      r_tmr_load   <= w_nxt_tmr_load;
      r_tmr_mode   <= w_nxt_tmr_mode;
      r_tmr_preset <= w_nxt_tmr_preset;
      r_err        <= w_nxt_err;
    end
  end

`ifdef TIMER_4BIT_SCHED_WDOG_EN
  // Counts RUN cycles since the last LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_nxt_wdog;
    end
  end
`endif

  assign ack        = r_ack;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;
  assign tmr_enable = r_tmr_enable;
  assign tmr_load   = r_tmr_load;
  assign tmr_mode   = r_tmr_mode;
  assign tmr_preset = r_tmr_preset;
  assign err        = r_err;

endmodule

// File: tb/tb_timer_4bit_sched.sv
// Directed bench for timer_4bit_sched with a behavioural timer_4bit model.
// Watchdog expectations follow TIMER_4BIT_SCHED_WDOG_EN.
module tb_timer_4bit_sched;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] req_delay;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        tmr_enable;
  logic        tmr_load;
  logic        tmr_mode;
  logic [3:0]  tmr_preset;
  logic        tmr_done;
  logic        err;

  logic [3:0]  tmr_cnt;
  logic        done_force_lo;

  int n_vec;
  int n_err;

  timer_4bit_sched #(.N_REQ(4), .ID_W(2), .WDOG_LIMIT(20)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_delay  (req_delay),
    .ack        (ack),
    .busy       (busy),
    .grant_id   (grant_id),
    .tmr_enable (tmr_enable),
    .tmr_load   (tmr_load),
    .tmr_mode   (tmr_mode),
    .tmr_preset (tmr_preset),
    .tmr_done   (tmr_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Timer model: load wins, countdown saturates at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_cnt <= '0;
    end else if (tmr_load) begin
      tmr_cnt <= tmr_preset;
    end else if (tmr_mode && tmr_enable && tmr_cnt != 4'd0) begin
      tmr_cnt <= tmr_cnt - 4'd1;
    end
  end

  assign tmr_done = !done_force_lo && tmr_mode && (tmr_cnt == 4'd0);

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_gid"}, int'(grant_id), 0);
    chk({tag, "_en"}, int'(tmr_enable), 0);
    chk({tag, "_load"}, int'(tmr_load), 0);
    chk({tag, "_mode"}, int'(tmr_mode), 0);
    chk({tag, "_preset"}, int'(tmr_preset), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Called in the IDLE cycle where req is first sampled; returns in the ack cycle.
  task automatic run_service(input int id, input int d, input bit drop);
    tick();
    chk("load", int'(tmr_load), 1);
    chk("load_mode", int'(tmr_mode), 1);
    chk("load_en", int'(tmr_enable), 0);
    chk("preset", int'(tmr_preset), d);
    chk("gid", int'(grant_id), id);
    chk("busy_load", int'(busy), 1);
    for (int i = 0; i <= d; i++) begin
      tick();
      chk("run_en", int'(tmr_enable), 1);
      chk("run_ack", int'(ack), 0);
    end
    tick();
    chk("ack", int'(ack), 1 << id);
    chk("done_en", int'(tmr_enable), 0);
    chk("done_busy", int'(busy), 1);
    chk("done_err", int'(err), 0);
    if (drop) req[id] = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    tick();
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ack"}, int'(ack), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};
  int seen_ack;
  int seen_err;

  initial begin
    clk = 1'b0; reset_n = 1'b0; req = '0; req_delay = '0; done_force_lo = 1'b0;
    n_vec = 0; n_err = 0;
    #12;
    chk_all_zero("rst");
    tick();
    reset_n = 1'b1;

    // Single requester 1, delay 4.
    req_delay = 16'h0040; req = 4'b0010;
    run_service(1, 4, 1'b1);
    chk_idle("t1_idle");

    // Delay 0: one RUN cycle.
    req_delay = 16'h0000; req = 4'b0001;
    run_service(0, 0, 1'b1);
    chk_idle("t2_idle");

    // Simultaneous req 0 and 2 after reset.
    do_reset();
    req_delay = 16'h0202; req = 4'b0101;
    run_service(0, 2, 1'b1);
    chk_idle("t3_gap");
    run_service(2, 2, 1'b1);
    chk_idle("t3_idle");

    // All four held continuously.
    do_reset();
    req_delay = 16'h1111; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_service(order[i], 1, 1'b0);
      if (i == 4) req = 4'b0000;
      chk_idle("t4_gap");
    end

    // Async reset in the middle of RUN.
    req_delay = 16'h0800; req = 4'b0100;
    tick();
    chk("t5_load", int'(tmr_load), 1);
    repeat (3) begin
      tick();
      chk("t5_run", int'(tmr_enable), 1);
    end
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t5_async");
    req = 4'b0000;
    repeat (3) begin
      tick();
      chk("t5_noack", int'(ack), 0);
    end
    reset_n = 1'b1;
    req_delay = 16'h3000; req = 4'b1000;
    run_service(3, 3, 1'b1);
    chk_idle("t5_idle");

    // rr_ptr cleared by reset: after serving 1 (ptr=2), reset, then 0 wins over 1.
    req_delay = 16'h0000; req = 4'b0010;
    run_service(1, 0, 1'b1);
    chk_idle("t5b_idle");
    do_reset();
    req = 4'b0011;
    run_service(0, 0, 1'b1);
    chk_idle("t5b_gap");
    run_service(1, 0, 1'b1);
    chk_idle("t5b_end");

    // Timer never reports done.
    done_force_lo = 1'b1;
    req_delay = 16'h0005; req = 4'b0001;
`ifdef TIMER_4BIT_SCHED_WDOG_EN
    tick();
    chk("t6_load", int'(tmr_load), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_run", int'(tmr_enable), 1);
      chk("t6_run_err", int'(err), 0);
    end
    tick();
    chk("t6_ack", int'(ack), 1);
    chk("t6_err", int'(err), 1);
    req = 4'b0000;
    tick();
    chk("t6_err_clr", int'(err), 0);
    chk("t6_idle", int'(busy), 0);
`else
    seen_ack = 0; seen_err = 0;
    repeat (40) begin
      tick();
      if (ack != 4'b0000) seen_ack = 1;
      if (err) seen_err = 1;
    end
    chk("t6_noack", seen_ack, 0);
    chk("t6_noerr", seen_err, 0);
    chk("t6_stuck_busy", int'(busy), 1);
    req = 4'b0000;
`endif
    done_force_lo = 1'b0;
    do_reset();
    tick();
    chk("end_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
